ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Param RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_req_valid  out  1  fetch request present.
REQ-005 imem_req_ready  in  1  memory accepts request this cycle.
REQ-006 imem_req_addr  out  64  fetch address, equals current PC.
REQ-007 imem_resp_valid  in  1  response data valid this cycle.
REQ-008 imem_resp_data  in  32  fetched instruction word.
REQ-009 redirect_valid  in  1  control transfer taken (jal/jalr).
REQ-010 redirect_pc  in  64  target of control transfer.
REQ-011 halt  in  1  ebreak seen downstream; stop fetching.
REQ-012 inst_valid  out  1  instruction held for decoder.
REQ-013 inst_ready  in  1  decoder consumes instruction this cycle.
REQ-014 inst  out  32  instruction to decoder.
REQ-015 inst_pc  out  64  PC of inst.
REQ-016 misalign_err  out  1  sticky; redirect target not 4-byte aligned.
REQ-017 fetch_count  out  64  number of instructions delivered (inst_valid & inst_ready).

Function
REQ-018 FSM states REQ, WAIT, DROP, HOLD, HALTED shall be implemented.
REQ-019 REQ: imem_req_valid=1; on imem_req_ready go WAIT.
REQ-020 WAIT: on imem_resp_valid latch data into inst register, go HOLD; inst_valid=1 in the following cycle (one-cycle response-to-decoder latency).
REQ-021 HOLD: inst_valid=1, inst/inst_pc stable until inst_ready; on inst_ready PC<=PC+4, go REQ.
REQ-022 Memory shall not return a response in the acceptance cycle; IFU ignores imem_resp_valid outside WAIT/DROP.
REQ-023 Redirect in REQ: PC<=redirect_pc, stay REQ; request that cycle, if accepted, shall be treated as stale (go DROP).
REQ-024 Redirect in WAIT: PC<=redirect_pc, go DROP; DROP discards next response then goes REQ.
REQ-025 Redirect in HOLD: held inst discarded (inst_valid=0 next cycle), PC<=redirect_pc, go REQ; if inst_ready same cycle, handshake counts (fetch_count increments) and redirect_pc still wins over PC+4.
REQ-026 Redirect with redirect_pc[1:0]!=0: misalign_err<=1, treated as halt.
REQ-027 halt (or misalignment) sets sticky halt flag; from REQ/HOLD go HALTED immediately; from WAIT/DROP wait for outstanding response, discard it, then HALTED.
REQ-028 HALTED: imem_req_valid=0, inst_valid=0, redirects ignored; exit only by reset.
REQ-029 halt and redirect same cycle: halt wins; PC not updated.
REQ-030 PC+4 and fetch_count shall wrap modulo 2^64 without error.

Reset
REQ-031 On rst: state=REQ, PC=RESET_PC, inst=0, inst_pc=0, inst_valid=0, misalign_err=0, halt flag=0, fetch_count=0.
REQ-032 imem_req_valid=1 with addr RESET_PC in first cycle after rst deasserts.
REQ-033 rst mid-transaction (WAIT/DROP): FSM returns to REQ; a late response arriving in REQ shall be ignored.

Structure
REQ-034 RESET_PC default, InstWidth, AddrWidth and FSM state encodings shall live in the shared defines file.
REQ-035 One sub-module ifu_pc_reg (PC register with reset value, +4 increment, redirect load) shall be used; FSM and inst buffer stay in ifu.

Verification
REQ-036 Reset, memory ready=1, 1-cycle response 32'h00000013 -> imem_req_addr=0x80000000, inst_valid two cycles after acceptance, inst_pc=0x80000000, next addr 0x80000004.
REQ-037 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no new request, fetch_count unchanged.
REQ-038 Redirect to 0x80000100 while in WAIT -> following response dropped, next request addr 0x80000100, no inst_valid for dropped word.
REQ-039 Redirect to 0x80000200 with inst_ready in HOLD -> fetch_count+1, next addr 0x80000200 (not PC+4).
REQ-040 halt in WAIT -> response discarded, HALTED, imem_req_valid=0 permanently; redirect then ignored; rst restores fetch at 0x80000000.
REQ-041 Redirect to 0x80000102 -> misalign_err=1, HALTED, no further requests.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM encoding.
package ifu_pkg;

    localparam int          InstWidth        = 32;
    localparam int          AddrWidth        = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [2:0] {
        S_REQ    = 3'd0,
        S_WAIT   = 3'd1,
        S_DROP   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: reset value, sequential +4 step, redirect load.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter logic [AddrWidth-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] load_pc_i,
    input  logic                 inc_i,
    output logic [AddrWidth-1:0] pc_o
);

    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] pc_d;

    // Next PC: a load has priority over the increment; +4 wraps modulo 2^64.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + 64'd4;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: request/response FSM, single instruction buffer,
// redirect and halt handling, delivered-instruction counter.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [AddrWidth-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [AddrWidth-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [InstWidth-1:0] imem_resp_data,
    input  logic                 redirect_valid,
    input  logic [AddrWidth-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [InstWidth-1:0] inst,
    output logic [AddrWidth-1:0] inst_pc,
    output logic                 misalign_err,
    output logic [63:0]          fetch_count
);

    ifu_state_t           state_q, state_d;
    logic                 halt_q, halt_d;
    logic                 mis_q, mis_d;
    logic [InstWidth-1:0] inst_q, inst_d;
    logic [AddrWidth-1:0] inst_pc_q, inst_pc_d;
    logic [63:0]          cnt_q, cnt_d;

    logic                 pc_load;
    logic                 pc_inc;
    logic [AddrWidth-1:0] pc;

    logic                 redir_seen;
    logic                 misalign_now;
    logic                 stop_now;
    logic                 take_redir;

    ifu_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pc_load),
        .load_pc_i(redirect_pc),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    // Classify this cycle's control inputs; halt (or a misaligned target) beats a redirect.
    always_comb begin
        redir_seen   = redirect_valid && (state_q != S_HALTED);
        misalign_now = redir_seen && (redirect_pc[1:0] != 2'b00);
        stop_now     = (halt || misalign_now) && (state_q != S_HALTED);
        take_redir   = redir_seen && !stop_now;
    end

    // Next-state, buffer update and handshake outputs.
    always_comb begin
        state_d        = state_q;
        halt_d         = halt_q;
        mis_d          = mis_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        cnt_d          = cnt_q;
        pc_load        = 1'b0;
        pc_inc         = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;

        if (stop_now) begin
            halt_d = 1'b1;
            if (misalign_now) begin
                mis_d = 1'b1;
            end
        end

        unique case (state_q)
            S_REQ: begin
                // No request is offered in a stopping cycle, so nothing is left in flight.
                imem_req_valid = !stop_now;
                if (stop_now) begin
                    state_d = S_HALTED;
                end else if (take_redir) begin
                    pc_load = 1'b1;
                    if (imem_req_ready) begin
                        state_d = S_DROP;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop_now || take_redir) begin
                    pc_load = take_redir;
                    // A response arriving in the same cycle is already the stale one.
                    if (imem_resp_valid) begin
                        state_d = stop_now ? S_HALTED : S_REQ;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_resp_valid) begin
                    inst_d    = imem_resp_data;
                    inst_pc_d = pc;
                    state_d   = S_HOLD;
                end
            end
            S_DROP: begin
                pc_load = take_redir;
                if (imem_resp_valid) begin
                    state_d = (halt_q || stop_now) ? S_HALTED : S_REQ;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    cnt_d = cnt_q + 64'd1;
                end
                if (stop_now) begin
                    state_d = S_HALTED;
                end else if (take_redir) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_inc  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State, sticky flags, instruction buffer and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            halt_q    <= 1'b0;
            mis_q     <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            mis_q     <= mis_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign imem_req_addr = pc;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign misalign_err  = mis_q;
    assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the instruction fetch unit.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign_err;
    logic [63:0] fetch_count;

    int checks = 0;
    int errors = 0;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;
        halt            = 1'b0;
        inst_ready      = 1'b0;
        tick();
        tick();
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_fetch_count", fetch_count, 64'd0);
        chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);

        // First cycle out of reset: request at the reset PC.
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);

        // Basic fetch: accept, 1-cycle response, instruction held.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        chk("wait_no_inst", {63'd0, inst_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        chk("hold_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("hold_inst", {32'd0, inst}, 64'h13);
        chk("hold_inst_pc", inst_pc, 64'h8000_0000);

        // Decoder stalls for 5 cycles: everything stays put.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("stall_inst", {32'd0, inst}, 64'h13);
            chk("stall_inst_pc", inst_pc, 64'h8000_0000);
            chk("stall_no_req", {63'd0, imem_req_valid}, 64'd0);
            chk("stall_count", fetch_count, 64'd0);
        end

        // Consume: PC steps by 4.
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("consume_count", fetch_count, 64'd1);
        chk("consume_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("next_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("next_req_addr", imem_req_addr, 64'h8000_0004);

        // Redirect while waiting: response dropped, refetch at target.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_no_req", {63'd0, imem_req_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("drop_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("drop_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("drop_req_addr", imem_req_addr, 64'h8000_0100);
        chk("drop_inst_kept", {32'd0, inst}, 64'h13);

        // Fetch at the redirect target.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        tick();
        imem_resp_valid = 1'b0;
        chk("tgt_inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("tgt_inst", {32'd0, inst}, 64'h0010_0093);
        chk("tgt_inst_pc", inst_pc, 64'h8000_0100);

        // Redirect together with consume: handshake counts, target beats PC+4.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_hold_count", fetch_count, 64'd2);
        chk("redir_hold_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("redir_hold_addr", imem_req_addr, 64'h8000_0200);
        chk("redir_hold_req", {63'd0, imem_req_valid}, 64'd1);

        // Halt while waiting: outstanding response discarded, then halted for good.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_wait_no_req", {63'd0, imem_req_valid}, 64'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_0001;
        tick();
        imem_resp_valid = 1'b0;
        chk("halted_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("halted_no_req", {63'd0, imem_req_valid}, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("halted_redir_ignored_req", {63'd0, imem_req_valid}, 64'd0);
        chk("halted_redir_ignored_addr", imem_req_addr, 64'h8000_0200);
        chk("halted_count", fetch_count, 64'd2);
        chk("halted_inst_kept", {32'd0, inst}, 64'h0010_0093);

        // Reset recovers fetching at the reset PC.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rerst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rerst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("rerst_count", fetch_count, 64'd0);

        // Reset during WAIT: a late response in REQ is ignored.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        chk("late_resp_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("late_resp_req", {63'd0, imem_req_valid}, 64'd1);
        chk("late_resp_inst", {32'd0, inst}, 64'd0);

        // Misaligned redirect: error flag, halted, no further requests.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        #1;
        chk("mis_req_suppressed", {63'd0, imem_req_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        chk("mis_err", {63'd0, misalign_err}, 64'd1);
        chk("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        chk("mis_still_no_req", {63'd0, imem_req_valid}, 64'd0);
        chk("mis_err_sticky", {63'd0, misalign_err}, 64'd1);
        chk("mis_no_inst", {63'd0, inst_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
